cc_alu_seq: RTL

CC_ALU_SEQ -- requirements
Module: cc_alu_seq

---
 rtl/cc_alu_seq_pkg.sv | 53 +++++
 rtl/cc_alu_seq_addsub.sv | 30 +++
 rtl/cc_alu_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cc_alu_seq_pkg.sv
// Shared definitions for the sequential condition-code ALU: opcode values,
// FSM state encoding, flag bit positions and small opcode classifiers.
package cc_alu_seq_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_ANDCC = 4'b0000;
    localparam logic [OPW-1:0] OP_ORCC  = 4'b0001;
    localparam logic [OPW-1:0] OP_NORCC = 4'b0010;
    localparam logic [OPW-1:0] OP_ADDCC = 4'b0011;
    localparam logic [OPW-1:0] OP_SUBCC = 4'b0100;
    localparam logic [OPW-1:0] OP_AND   = 4'b0101;
    localparam logic [OPW-1:0] OP_OR    = 4'b0110;
    localparam logic [OPW-1:0] OP_NOR   = 4'b0111;
    localparam logic [OPW-1:0] OP_ADD   = 4'b1000;
    localparam logic [OPW-1:0] OP_SUB   = 4'b1001;
    localparam logic [OPW-1:0] OP_SLL   = 4'b1010;
    localparam logic [OPW-1:0] OP_SRL   = 4'b1011;
    localparam logic [OPW-1:0] OP_SRA   = 4'b1100;
    localparam logic [OPW-1:0] OP_MULCC = 4'b1101;
    localparam logic [OPW-1:0] OP_INCPC = 4'b1110;
    localparam logic [OPW-1:0] OP_PASSA = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_MUL   = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Bit positions inside the packed {N,Z,V,C} flag register.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    // Condition-code opcodes that complete in a single cycle (MULCC is
    // handled separately because its flags come from the multiplier).
    function automatic logic isFlagOp1(input logic [OPW-1:0] op);
        case (op)
            OP_ANDCC, OP_ORCC, OP_NORCC, OP_ADDCC, OP_SUBCC: isFlagOp1 = 1'b1;
            default:                                         isFlagOp1 = 1'b0;
        endcase
    endfunction

    function automatic logic isShiftOp(input logic [OPW-1:0] op);
        case (op)
            OP_SLL, OP_SRL, OP_SRA: isShiftOp = 1'b1;
            default:                isShiftOp = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cc_alu_seq_addsub.sv
// Combinational adder/subtractor. carry is the carry-out for addition and
// the borrow (opA < opB unsigned) for subtraction; overflow is signed overflow.
module cc_alu_seq_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             subtract,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] ext_s;

    // Zero-extended add/subtract; the extra top bit is carry or borrow.
    always_comb begin
        if (subtract) begin
            ext_s    = {1'b0, opA} - {1'b0, opB};
            sum      = ext_s[WIDTH-1:0];
            overflow = (opA[WIDTH-1] != opB[WIDTH-1]) && (sum[WIDTH-1] != opA[WIDTH-1]);
        end else begin
            ext_s    = {1'b0, opA} + {1'b0, opB};
            sum      = ext_s[WIDTH-1:0];
            overflow = (opA[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != opA[WIDTH-1]);
        end
        carry = ext_s[WIDTH];
    end

endmodule

// File: rtl/cc_alu_seq.sv
// Sequential condition-code ALU: single-cycle logic/arithmetic, bit-serial
// shifts and an optional shift-add multiplier.
// Optional feature: define CC_ALU_SEQ_MUL_EN to build the MULCC multiplier;
// without it opcode 1101 behaves like PASSA.
module cc_alu_seq
    import cc_alu_seq_pkg::*;
#(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_ALU_SELECTION = 4
) (
    input  logic                               CC_ALU_SEQ_CLOCK_50,
    input  logic                               CC_ALU_SEQ_RESET_InHigh,
    input  logic                               CC_ALU_SEQ_Start_InHigh,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALU_SEQ_Selection_In,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_DataBUSA_In,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_DataBUSB_In,
    output logic                               CC_ALU_SEQ_Ready_OutHigh,
    output logic                               CC_ALU_SEQ_Done_OutHigh,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALU_SEQ_DataBUS_Out,
    output logic                               CC_ALU_SEQ_Negative_OutHigh,
    output logic                               CC_ALU_SEQ_Zero_OutHigh,
    output logic                               CC_ALU_SEQ_Overflow_OutHigh,
    output logic                               CC_ALU_SEQ_Carry_OutHigh
);

    localparam int W   = DATAWIDTH_BUS;
    localparam int SHW = $clog2(DATAWIDTH_BUS);
    localparam logic [SHW-1:0] SH_ONE = SHW'(1);

    state_e           state_r;
    logic [OPW-1:0]   opcode_r;
    logic [W-1:0]     shiftReg_r;
    logic [SHW-1:0]   shiftCnt_r;
    logic [W-1:0]     result_r;
    logic [3:0]       flags_r;
    logic             done_r;
    logic             ready_r;

    logic [OPW-1:0]   opSel_s;
    logic [SHW-1:0]   shAmt_s;
    logic [W-1:0]     addB_s;
    logic             addSub_s;
    logic [W-1:0]     sum_s;
    logic             carry_s;
    logic             overflow_s;
    logic [W-1:0]     singleRes_s;
    logic             singleV_s;
    logic             singleC_s;
    logic [W-1:0]     shiftNext_s;

    assign opSel_s = CC_ALU_SEQ_Selection_In[OPW-1:0];
    assign shAmt_s = CC_ALU_SEQ_DataBUSB_In[SHW-1:0];

    function automatic logic [3:0] makeFlags(input logic [W-1:0] res, input logic v, input logic c);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = res[W-1];
        f[FLAG_Z] = (res == '0);
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

    cc_alu_seq_addsub #(.WIDTH(W)) uAddSub (
        .opA      (CC_ALU_SEQ_DataBUSA_In),
        .opB      (addB_s),
        .subtract (addSub_s),
        .sum      (sum_s),
        .carry    (carry_s),
        .overflow (overflow_s)
    );

    // Result and V/C for every opcode that finishes in the accept cycle.
    always_comb begin
        addSub_s    = (opSel_s == OP_SUBCC) || (opSel_s == OP_SUB);
        if (opSel_s == OP_INCPC) begin
            addB_s = W'(32'd4);
        end else begin
            addB_s = CC_ALU_SEQ_DataBUSB_In;
        end
        singleRes_s = CC_ALU_SEQ_DataBUSA_In;
        singleV_s   = 1'b0;
        singleC_s   = 1'b0;
        case (opSel_s)
            OP_ANDCC, OP_AND: singleRes_s = CC_ALU_SEQ_DataBUSA_In & CC_ALU_SEQ_DataBUSB_In;
            OP_ORCC,  OP_OR:  singleRes_s = CC_ALU_SEQ_DataBUSA_In | CC_ALU_SEQ_DataBUSB_In;
            OP_NORCC, OP_NOR: singleRes_s = ~(CC_ALU_SEQ_DataBUSA_In | CC_ALU_SEQ_DataBUSB_In);
            OP_ADDCC, OP_SUBCC, OP_ADD, OP_SUB, OP_INCPC: begin
                singleRes_s = sum_s;
                singleV_s   = overflow_s;
                singleC_s   = carry_s;
            end
            default: singleRes_s = CC_ALU_SEQ_DataBUSA_In;
        endcase
    end

    // One-bit shift step for the latched shift opcode.
    always_comb begin
        case (opcode_r)
            OP_SLL:  shiftNext_s = shiftReg_r << 1;
            OP_SRL:  shiftNext_s = shiftReg_r >> 1;
            OP_SRA:  shiftNext_s = {shiftReg_r[W-1], shiftReg_r[W-1:1]};
            default: shiftNext_s = shiftReg_r;
        endcase
    end

`ifdef CC_ALU_SEQ_MUL_EN
    localparam logic [SHW:0] MUL_CYCLES = (SHW+1)'(DATAWIDTH_BUS);
    localparam logic [SHW:0] MUL_LAST   = (SHW+1)'(1);

    logic [2*W-1:0] mulAcc_r;
    logic [2*W-1:0] mulCand_r;
    logic [W-1:0]   mulPlier_r;
    logic [SHW:0]   mulCnt_r;
    logic [2*W-1:0] mulAccNext_s;

    // Shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    always_comb begin
        if (mulPlier_r[0]) begin
            mulAccNext_s = mulAcc_r + mulCand_r;
        end else begin
            mulAccNext_s = mulAcc_r;
        end
    end
`endif

    // Control FSM with registered result, flags, Ready and Done.
    always_ff @(posedge CC_ALU_SEQ_CLOCK_50) begin
        if (CC_ALU_SEQ_RESET_InHigh) begin
            state_r    <= ST_IDLE;
            opcode_r   <= '0;
            shiftReg_r <= '0;
            shiftCnt_r <= '0;
            result_r   <= '0;
            flags_r    <= 4'b0000;
            done_r     <= 1'b0;
            ready_r    <= 1'b1;
`ifdef CC_ALU_SEQ_MUL_EN
            mulAcc_r   <= '0;
            mulCand_r  <= '0;
            mulPlier_r <= '0;
            mulCnt_r   <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (CC_ALU_SEQ_Start_InHigh) begin
                        opcode_r <= opSel_s;
                        if (isShiftOp(opSel_s) && (shAmt_s != '0)) begin
                            shiftReg_r <= CC_ALU_SEQ_DataBUSA_In;
                            shiftCnt_r <= shAmt_s;
                            state_r    <= ST_SHIFT;
                            ready_r    <= 1'b0;
                        end
`ifdef CC_ALU_SEQ_MUL_EN
                        else if (opSel_s == OP_MULCC) begin
                            mulAcc_r   <= '0;
                            mulCand_r  <= {{W{1'b0}}, CC_ALU_SEQ_DataBUSA_In};
                            mulPlier_r <= CC_ALU_SEQ_DataBUSB_In;
                            mulCnt_r   <= MUL_CYCLES;
                            state_r    <= ST_MUL;
                            ready_r    <= 1'b0;
                        end
`endif
                        else begin
                            result_r <= singleRes_s;
                            if (isFlagOp1(opSel_s)) begin
                                flags_r <= makeFlags(singleRes_s, singleV_s, singleC_s);
                            end else begin
                                flags_r <= flags_r;
                            end
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                            ready_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    shiftReg_r <= shiftNext_s;
                    shiftCnt_r <= shiftCnt_r - SH_ONE;
                    if (shiftCnt_r == SH_ONE) begin
                        result_r <= shiftNext_s;
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                        ready_r  <= 1'b1;
                    end else begin
                        ready_r  <= 1'b0;
                    end
                end
`ifdef CC_ALU_SEQ_MUL_EN
                ST_MUL: begin
                    mulAcc_r   <= mulAccNext_s;
                    mulCand_r  <= mulCand_r << 1;
                    mulPlier_r <= mulPlier_r >> 1;
                    mulCnt_r   <= mulCnt_r - MUL_LAST;
                    if (mulCnt_r == MUL_LAST) begin
                        result_r <= mulAccNext_s[W-1:0];
                        flags_r  <= makeFlags(mulAccNext_s[W-1:0],
                                              mulAccNext_s[2*W-1:W] != '0,
                                              mulAccNext_s[2*W-1:W] != '0);
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                        ready_r  <= 1'b1;
                    end else begin
                        ready_r  <= 1'b0;
                    end
                end
`else
                ST_MUL: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign CC_ALU_SEQ_Ready_OutHigh    = ready_r;
    assign CC_ALU_SEQ_Done_OutHigh     = done_r;
    assign CC_ALU_SEQ_DataBUS_Out      = result_r;
    assign CC_ALU_SEQ_Negative_OutHigh = flags_r[FLAG_N];
    assign CC_ALU_SEQ_Zero_OutHigh     = flags_r[FLAG_Z];
    assign CC_ALU_SEQ_Overflow_OutHigh = flags_r[FLAG_V];
    assign CC_ALU_SEQ_Carry_OutHigh    = flags_r[FLAG_C];

endmodule
